// File: rtl/gpu_mem_arb_pkg.sv
// rtl/gpu_mem_arb_pkg.sv - shared types and helpers for the GPU memory port arbiter
// Contents:
//   arb_state_t    FSM states; LOCKED exists only when GPU_MEM_ARB_LOCK_EN is defined
//   CMD_SIZE_*     DDR command size codes (0=8B, 1=32B)
//   rr_pick        round-robin selector returning a one-hot grant
//   onehot_idx     one-hot to index encoder
package gpu_mem_arb_pkg;

  localparam int RR_MAX   = 8;
  localparam int RR_PTR_W = 3;

  localparam logic [1:0] CMD_SIZE_8B  = 2'd0;
  localparam logic [1:0] CMD_SIZE_32B = 2'd1;

`ifdef GPU_MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2} arb_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} arb_state_t;
`endif

  // First set bit of req at or after ptr, wrapping at n (n <= RR_MAX).
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0]   req,
                                               input logic [RR_PTR_W-1:0] ptr,
                                               input int                  n);
    logic [RR_PTR_W:0] idx;
    logic              found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        idx = {1'b0, ptr} + (RR_PTR_W+1)'(k);
        if (idx >= (RR_PTR_W+1)'(n)) idx = idx - (RR_PTR_W+1)'(n);
        if (!found && req[idx[RR_PTR_W-1:0]]) begin
          rr_pick[idx[RR_PTR_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [RR_PTR_W-1:0] onehot_idx(input logic [RR_MAX-1:0] oh);
    onehot_idx = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (oh[k]) onehot_idx = RR_PTR_W'(k);
    end
  endfunction

endpackage

// File: rtl/gpu_mem_arb_tagfifo.sv
// rtl/gpu_mem_arb_tagfifo.sv - in-order FIFO of requester tags for outstanding reads
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (empties the FIFO)
//   push, tag_in   enqueue tag_in (ignored when full)
//   pop            dequeue head (ignored when empty)
//   full, empty    occupancy flags
//   head           tag at the front of the FIFO
module gpu_mem_arb_tagfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] tag_in,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= tag_in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_mem_port_arbiter.sv
// rtl/gpu_mem_port_arbiter.sv - round-robin arbiter sharing the DDR command port among GPU memory engines
// Optional feature macro: GPU_MEM_ARB_LOCK_EN (grant lock for back-to-back read-modify-write).
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_req_* (per requester)     command, size, write, adr, subadr, writeMask, dataOut, lock
//   o_req_accept                one-cycle pulse when the DDR port takes the command
//   o_req_dataInValid, o_dataIn read return strobe (routed by tag) and broadcast data
//   o_command .. o_dataOut      granted command toward the DDR controller
//   i_busy                      DDR busy; command taken when o_command & !i_busy
//   i_dataInValid, i_dataIn     DDR read return
//   o_tagFull                   TAG_DEPTH reads outstanding
//   o_error                     sticky: read data returned with no outstanding read
module gpu_mem_port_arbiter
  import gpu_mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req_command,
  input  logic [NUM_REQ*2-1:0]   i_req_size,
  input  logic [NUM_REQ-1:0]     i_req_write,
  input  logic [NUM_REQ*15-1:0]  i_req_adr,
  input  logic [NUM_REQ*3-1:0]   i_req_subadr,
  input  logic [NUM_REQ*16-1:0]  i_req_writeMask,
  input  logic [NUM_REQ*256-1:0] i_req_dataOut,
  input  logic [NUM_REQ-1:0]     i_req_lock,
  output logic [NUM_REQ-1:0]     o_req_accept,
  output logic [NUM_REQ-1:0]     o_req_dataInValid,
  output logic [255:0]           o_dataIn,
  output logic                   o_command,
  input  logic                   i_busy,
  output logic [1:0]             o_commandSize,
  output logic                   o_write,
  output logic [14:0]            o_adr,
  output logic [2:0]             o_subadr,
  output logic [15:0]            o_writeMask,
  output logic [255:0]           o_dataOut,
  input  logic                   i_dataInValid,
  input  logic [255:0]           i_dataIn,
  output logic                   o_tagFull,
  output logic                   o_error
);

  localparam int TAG_W = $clog2(NUM_REQ);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [TAG_W-1:0]  grant;
  logic [TAG_W-1:0]  grant_next;
  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  rr_ptr_next;
  logic [TAG_W-1:0]  grant_inc;
  logic              error_q;

  logic [NUM_REQ-1:0] eligible;
  logic [RR_MAX-1:0]  elig_pad;
  logic [RR_MAX-1:0]  pick_onehot;
  logic [TAG_W-1:0]   pick_idx;
  logic               accept;

  logic               tag_push;
  logic               tag_full;
  logic               tag_empty;
  logic [TAG_W-1:0]   tag_head;

`ifndef GPU_MEM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^i_req_lock;
`endif

  // Reads are held back while every tag slot is in use; writes never need a tag.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = i_req_command[i] & (i_req_write[i] | ~tag_full);
    end
  end

  always_comb begin
    elig_pad = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_pad[i] = eligible[i];
    end
  end

  assign pick_onehot = rr_pick(elig_pad, RR_PTR_W'(rr_ptr), NUM_REQ);
  assign pick_idx    = TAG_W'(onehot_idx(pick_onehot));
  assign grant_inc   = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);

  assign accept   = (state == GRANT) & ~i_busy;
  assign tag_push = accept & ~i_req_write[grant];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      error_q <= 1'b0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
      if (i_dataInValid && tag_empty) error_q <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (|eligible) begin
          grant_next = pick_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!i_busy) begin
`ifdef GPU_MEM_ARB_LOCK_EN
          // A locked requester keeps the port; the rr pointer stays put so the
          // others resume from where they were once the lock is released.
          if (i_req_lock[grant]) begin
            state_next = LOCKED;
          end else begin
            state_next  = IDLE;
            rr_ptr_next = grant_inc;
          end
`else
          state_next  = IDLE;
          rr_ptr_next = grant_inc;
`endif
        end
      end
`ifdef GPU_MEM_ARB_LOCK_EN
      LOCKED: begin
        // A new command from the owner is served even if it arrives with lock
        // already dropped, so the final access of a sequence stays back-to-back.
        if (eligible[grant]) begin
          state_next = GRANT;
        end else if (!i_req_lock[grant]) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_command     = 1'b0;
    o_commandSize = CMD_SIZE_8B;
    o_write       = 1'b0;
    o_adr         = '0;
    o_subadr      = '0;
    o_writeMask   = '0;
    o_dataOut     = '0;
    if (state == GRANT) begin
      o_command = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant == TAG_W'(i)) begin
          o_commandSize = i_req_size[i*2 +: 2];
          o_write       = i_req_write[i];
          o_adr         = i_req_adr[i*15 +: 15];
          o_subadr      = i_req_subadr[i*3 +: 3];
          o_writeMask   = i_req_writeMask[i*16 +: 16];
          o_dataOut     = i_req_dataOut[i*256 +: 256];
        end
      end
    end
  end

  always_comb begin
    o_req_accept      = '0;
    o_req_dataInValid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_accept[i]      = accept & (grant == TAG_W'(i));
      o_req_dataInValid[i] = i_dataInValid & ~tag_empty & (tag_head == TAG_W'(i));
    end
  end

  assign o_dataIn  = i_dataIn;
  assign o_tagFull = tag_full;
  assign o_error   = error_q;

  gpu_mem_arb_tagfifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TAG_W)
  ) u_tagfifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push   (tag_push),
    .tag_in (grant),
    .pop    (i_dataInValid),
    .full   (tag_full),
    .empty  (tag_empty),
    .head   (tag_head)
  );

  // The granted requester must hold its bundle until accepted.
  a_hold_req: assert property (@(posedge i_clk) disable iff (i_rst)
    (state == GRANT) |-> i_req_command[grant]);

  a_size_legal: assert property (@(posedge i_clk) disable iff (i_rst)
    (state == GRANT) |-> (o_commandSize == CMD_SIZE_8B || o_commandSize == CMD_SIZE_32B));

endmodule

// File: tb/tb_gpu_mem_port_arbiter.sv
// tb/tb_gpu_mem_port_arbiter.sv - self-checking bench for gpu_mem_port_arbiter
module tb_gpu_mem_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int TAG_DEPTH = 4;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic [NUM_REQ-1:0]     req_command = '0;
  logic [NUM_REQ*2-1:0]   req_size = '0;
  logic [NUM_REQ-1:0]     req_write = '0;
  logic [NUM_REQ*15-1:0]  req_adr = '0;
  logic [NUM_REQ*3-1:0]   req_subadr = '0;
  logic [NUM_REQ*16-1:0]  req_mask = '0;
  logic [NUM_REQ*256-1:0] req_data = '0;
  logic [NUM_REQ-1:0]     req_lock = '0;
  logic                   i_busy = 1'b0;
  logic                   i_dataInValid = 1'b0;
  logic [255:0]           i_dataIn = '0;

  logic [NUM_REQ-1:0] o_req_accept;
  logic [NUM_REQ-1:0] o_req_dataInValid;
  logic [255:0]       o_dataIn;
  logic               o_command;
  logic [1:0]         o_commandSize;
  logic               o_write;
  logic [14:0]        o_adr;
  logic [2:0]         o_subadr;
  logic [15:0]        o_writeMask;
  logic [255:0]       o_dataOut;
  logic               o_tagFull;
  logic               o_error;

  gpu_mem_port_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_req_command     (req_command),
    .i_req_size        (req_size),
    .i_req_write       (req_write),
    .i_req_adr         (req_adr),
    .i_req_subadr      (req_subadr),
    .i_req_writeMask   (req_mask),
    .i_req_dataOut     (req_data),
    .i_req_lock        (req_lock),
    .o_req_accept      (o_req_accept),
    .o_req_dataInValid (o_req_dataInValid),
    .o_dataIn          (o_dataIn),
    .o_command         (o_command),
    .i_busy            (i_busy),
    .o_commandSize     (o_commandSize),
    .o_write           (o_write),
    .o_adr             (o_adr),
    .o_subadr          (o_subadr),
    .o_writeMask       (o_writeMask),
    .o_dataOut         (o_dataOut),
    .i_dataInValid     (i_dataInValid),
    .i_dataIn          (i_dataIn),
    .o_tagFull         (o_tagFull),
    .o_error           (o_error)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mg: requester currently presented on the port (-1 none)
  // locked: requester owning the port between locked commands (-1 none)
  int  mg = -1;
  int  locked = -1;
  int  rr = 0;
  int  q[$];
  bit  err = 1'b0;
  bit  model_live = 1'b0;
  bit  full_now;
  int  nxt;
  int  push_tag;
  int  cidx;

  always @(posedge i_clk) begin
    if (i_rst) begin
      mg = -1; locked = -1; rr = 0; q.delete(); err = 1'b0; model_live = 1'b1;
    end else if (model_live) begin
      full_now = (q.size() == TAG_DEPTH);
      nxt = mg;
      push_tag = -1;
      if (mg >= 0) begin
        if (!i_busy) begin
          if (!req_write[mg]) push_tag = mg;
          nxt = -1;
`ifdef GPU_MEM_ARB_LOCK_EN
          if (req_lock[mg]) locked = mg;
          else rr = (mg + 1) % NUM_REQ;
`else
          rr = (mg + 1) % NUM_REQ;
`endif
        end
      end else if (locked >= 0) begin
        if (req_command[locked] && (req_write[locked] || !full_now)) begin
          nxt = locked; locked = -1;
        end else if (!req_lock[locked]) begin
          locked = -1;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cidx = (rr + k) % NUM_REQ;
          if (nxt < 0 && req_command[cidx] && (req_write[cidx] || !full_now)) nxt = cidx;
        end
      end
      if (i_dataInValid) begin
        if (q.size() > 0) void'(q.pop_front());
        else err = 1'b1;
      end
      if (push_tag >= 0) q.push_back(push_tag);
      mg = nxt;
    end
  end

  logic [NUM_REQ-1:0] e_acc, e_dv;
  logic [1:0]         e_size;
  logic               e_wr;
  logic [14:0]        e_adr;
  logic [2:0]         e_sub;
  logic [15:0]        e_mask;
  logic [255:0]       e_data;

  always @(negedge i_clk) begin
    if (model_live) begin
      e_acc = '0; e_dv = '0; e_size = '0; e_wr = 1'b0; e_adr = '0; e_sub = '0; e_mask = '0; e_data = '0;
      if (mg >= 0) begin
        if (!i_busy) e_acc[mg] = 1'b1;
        e_size = req_size[mg*2 +: 2];
        e_wr   = req_write[mg];
        e_adr  = req_adr[mg*15 +: 15];
        e_sub  = req_subadr[mg*3 +: 3];
        e_mask = req_mask[mg*16 +: 16];
        e_data = req_data[mg*256 +: 256];
      end
      if (i_dataInValid && q.size() > 0) e_dv[q[0]] = 1'b1;
      check("command",     o_command,         mg >= 0);
      check("accept",      o_req_accept,      e_acc);
      check("size",        o_commandSize,     e_size);
      check("write",       o_write,           e_wr);
      check("adr",         o_adr,             e_adr);
      check("subadr",      o_subadr,          e_sub);
      check("writemask",   o_writeMask,       e_mask);
      check("dataout",     o_dataOut,         e_data);
      check("datainvalid", o_req_dataInValid, e_dv);
      check("datain",      o_dataIn,          i_dataIn);
      check("tagfull",     o_tagFull,         q.size() == TAG_DEPTH);
      check("error",       o_error,           err);
    end
  end

  // ---------------- stimulus helpers ----------------
  int                 run_cyc;
  int                 acc_cyc [NUM_REQ];
  logic [14:0]        adr_at_acc [NUM_REQ];
  logic [NUM_REQ-1:0] seen;
  logic [NUM_REQ-1:0] last_dv;
  logic [255:0]       last_din;
  logic [14:0]        last_adr;
  logic               last_cmd, last_full, last_err;
  int                 ncmd, nacc;

  task automatic cycle();
    @(negedge i_clk);
    run_cyc++;
    last_cmd  = o_command;
    last_full = o_tagFull;
    last_err  = o_error;
    last_dv   = o_req_dataInValid;
    last_din  = o_dataIn;
    last_adr  = o_adr;
    seen      = o_req_accept;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (seen[i]) begin
        acc_cyc[i]    = run_cyc;
        adr_at_acc[i] = o_adr;
      end
    end
    @(posedge i_clk);
    #1;
    req_command   = req_command & ~seen;
    i_dataInValid = 1'b0;
  endtask

  task automatic start_run();
    run_cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) acc_cyc[i] = 0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [14:0] adr);
    req_command[i]         = 1'b1;
    req_write[i]           = wr;
    req_size[i*2 +: 2]     = wr ? 2'd1 : 2'd0;
    req_adr[i*15 +: 15]    = adr;
    req_subadr[i*3 +: 3]   = adr[2:0];
    req_mask[i*16 +: 16]   = {adr, 1'b1};
    req_data[i*256 +: 256] = {16{adr, 1'b0}};
  endtask

  // Runs until every requester in wait_mask has been accepted, or for max_cyc
  // cycles when wait_mask is empty.
  task automatic run(input int max_cyc, input logic [NUM_REQ-1:0] wait_mask);
    start_run();
    for (int c = 0; c < max_cyc; c++) begin
      cycle();
      if (wait_mask != '0 && (req_command & wait_mask) == '0) break;
    end
    if (wait_mask != '0) check("run_done", req_command & wait_mask, '0);
  endtask

  task automatic pulse_return(input logic [255:0] data, input logic [NUM_REQ-1:0] exp_dv, input string name);
    i_dataInValid = 1'b1;
    i_dataIn      = data;
    cycle();
    check(name, last_dv, exp_dv);
    check({name, "_data"}, last_din, data);
  endtask

  task automatic fill_reads();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 1'b0, 15'(16'h0400 + i));
      run(6, NUM_REQ'(1) << i);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    cycle();
    check("reset_command", last_cmd, 1'b0);
    check("reset_error", last_err, 1'b0);

    // 1: two writes together, index 0 first, then 2
    set_req(0, 1'b1, 15'h0100);
    set_req(2, 1'b1, 15'h0222);
    run(8, 4'b0101);
    check("t1_req0_cycle", acc_cyc[0], 2);
    check("t1_req2_cycle", acc_cyc[2], 4);
    check("t1_req0_adr", adr_at_acc[0], 15'h0100);
    check("t1_req2_adr", adr_at_acc[2], 15'h0222);

    // 2: read held off by busy for 5 grant cycles
    start_run();
    i_busy = 1'b1;
    set_req(1, 1'b0, 15'h1234);
    ncmd = 0; nacc = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (last_cmd) begin
        ncmd++;
        check("t2_adr_hold", last_adr, 15'h1234);
      end
      if (seen[1]) nacc++;
      i_busy = (k < 6);
    end
    check("t2_cmd_cycles", ncmd, 6);
    check("t2_accepts", nacc, 1);
    check("t2_accept_cycle", acc_cyc[1], 7);
    pulse_return(256'h99, 4'b0010, "t2_return");

    // 3: read returns routed in order 1,3,1
    set_req(1, 1'b0, 15'h0011); run(6, 4'b0010);
    set_req(3, 1'b0, 15'h0033); run(6, 4'b1000);
    set_req(1, 1'b0, 15'h0012); run(6, 4'b0010);
    pulse_return(256'hA, 4'b0010, "t3_ret_a");
    pulse_return(256'hB, 4'b1000, "t3_ret_b");
    pulse_return(256'hC, 4'b0010, "t3_ret_c");

    // 4: tag FIFO full blocks reads, writes still pass
    fill_reads();
    cycle();
    check("t4_tagfull", last_full, 1'b1);
    set_req(0, 1'b0, 15'h0500);
    set_req(2, 1'b1, 15'h0522);
    run(4, 4'b0000);
    check("t4_write_cycle", acc_cyc[2], 2);
    check("t4_read_blocked", acc_cyc[0], 0);
    pulse_return(256'h40, 4'b0001, "t4_pop0");
    run(6, 4'b0001);
    pulse_return(256'h41, 4'b0010, "t4_pop1");
    pulse_return(256'h42, 4'b0100, "t4_pop2");
    pulse_return(256'h43, 4'b1000, "t4_pop3");
    pulse_return(256'h44, 4'b0001, "t4_pop4");

    // 5: return with nothing outstanding
    pulse_return(256'h55, 4'b0000, "t5_empty_pop");
    cycle();
    check("t5_error_set", last_err, 1'b1);
    cycle();
    check("t5_error_sticky", last_err, 1'b1);
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    cycle();
    check("t5_error_cleared", last_err, 1'b0);

`ifdef GPU_MEM_ARB_LOCK_EN
    // 6: locked requester keeps the port while req0 waits
    req_lock[1] = 1'b1;
    set_req(1, 1'b0, 15'h0601); run(6, 4'b0010);
    set_req(0, 1'b0, 15'h0600);
    set_req(1, 1'b0, 15'h0602); run(6, 4'b0010);
    check("t6_req0_wait_a", acc_cyc[0], 0);
    set_req(1, 1'b0, 15'h0603); run(6, 4'b0010);
    check("t6_req0_wait_b", acc_cyc[0], 0);
    run(3, 4'b0000);
    check("t6_req0_wait_c", acc_cyc[0], 0);
    req_lock[1] = 1'b0;
    run(6, 4'b0001);
    pulse_return(256'h61, 4'b0010, "t6_ret_a");
    pulse_return(256'h62, 4'b0010, "t6_ret_b");
    pulse_return(256'h63, 4'b0010, "t6_ret_c");
    pulse_return(256'h60, 4'b0001, "t6_ret_d");
`endif

    // reset while a command is presented and all tags are in use
    fill_reads();
    i_busy = 1'b1;
    set_req(3, 1'b1, 15'h7777);
    cycle();
    cycle();
    check("rst_pre_command", last_cmd, 1'b1);
    check("rst_pre_full", last_full, 1'b1);
    i_rst = 1'b1;
    req_command = '0;
    cycle();
    i_rst = 1'b0;
    i_busy = 1'b0;
    cycle();
    check("rst_command", last_cmd, 1'b0);
    check("rst_tagfull", last_full, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
